// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer and its helpers.
package pc_seq_pkg;

  localparam int DATA_W = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    TRAP  = 2'd2,
    HALT  = 2'd3
  } seq_state_e;

  localparam logic [DATA_W-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [DATA_W-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch port and decode/execute handshake between the sequencer, memory and execute.
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic              fetch_req;
  logic [DATA_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic [DATA_W-1:0] fetch_data;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] instr_pc;
  logic              exec_ready;
  logic              jump_taken;
  logic [DATA_W-1:0] jump_target;

  modport master (
    output fetch_req, fetch_addr, instr_valid, instr, instr_pc,
    input  fetch_ack, fetch_data, exec_ready, jump_taken, jump_target
  );

  modport slave (
    input  fetch_req, fetch_addr, instr_valid, instr, instr_pc,
    output fetch_ack, fetch_data, exec_ready, jump_taken, jump_target
  );

endinterface

// File: rtl/next_pc_select.sv
// Combinational next-PC choice: sequential successor or resolved jump target.
module next_pc_select
  import pc_seq_pkg::*;
(
  input  logic [DATA_W-1:0] instr_pc,
  input  logic              jump_taken,
  input  logic [DATA_W-1:0] jump_target,
  output logic [DATA_W-1:0] next_pc,
  output logic              misaligned
);

  logic [DATA_W-1:0] seq_pc;

  // Plain unsigned add: wraps from FFFF_FFFC to 0.
  assign seq_pc     = instr_pc + DATA_W'(INSTR_BYTES);
  assign next_pc    = jump_taken ? jump_target : seq_pc;
  assign misaligned = jump_taken & (jump_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner: fetch, issue to execute, jump/trap resolution, halt, retire count.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [DATA_W-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic              clk,
  input  logic              rst,
  pc_sequencer_if.master    bus,
  input  logic              halt,
  output logic              halted,
  output logic              trap,
  output logic [DATA_W-1:0] trap_pc,
  output logic [DATA_W-1:0] trap_tval,
  output logic [DATA_W-1:0] retire_count
);

  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_TRAP  = TRAP;
  localparam logic [1:0] ST_HALT  = HALT;

  logic [1:0]        state;
  logic              fetch_first;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] instr_pc_q;
  logic [DATA_W-1:0] trap_pc_q;
  logic [DATA_W-1:0] trap_tval_q;
  logic [DATA_W-1:0] retire_q;

  logic              in_fetch;
  logic              in_issue;
  logic              halt_on_entry;
  logic [DATA_W-1:0] next_pc;
  logic              misaligned;

  next_pc_select u_next_pc (
    .instr_pc    (instr_pc_q),
    .jump_taken  (bus.jump_taken),
    .jump_target (bus.jump_target),
    .next_pc     (next_pc),
    .misaligned  (misaligned)
  );

  assign in_fetch      = (state == ST_FETCH);
  assign in_issue      = (state == ST_ISSUE);
  // Halt is only honoured in the first FETCH cycle so an issued request is never abandoned.
  assign halt_on_entry = in_fetch & fetch_first & halt;

  assign bus.fetch_req   = in_fetch & ~halt_on_entry & ~rst;
  assign bus.fetch_addr  = pc;
  assign bus.instr_valid = in_issue;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

  assign halted       = (state == ST_HALT);
  assign trap         = (state == ST_TRAP);
  assign trap_pc      = trap_pc_q;
  assign trap_tval    = trap_tval_q;
  assign retire_count = retire_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FETCH;
      fetch_first <= 1'b1;
      pc          <= RESET_VECTOR;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      trap_pc_q   <= '0;
      trap_tval_q <= '0;
      retire_q    <= '0;
    end else begin
      fetch_first <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (halt_on_entry) begin
            state <= ST_HALT;
          end else if (bus.fetch_ack) begin
            instr_q    <= bus.fetch_data;
            instr_pc_q <= pc;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.exec_ready) begin
            if (misaligned) begin
              trap_pc_q   <= instr_pc_q;
              trap_tval_q <= next_pc;
              state       <= ST_TRAP;
            end else begin
              pc          <= next_pc;
              retire_q    <= retire_q + 1'b1;
              fetch_first <= 1'b1;
              state       <= ST_FETCH;
            end
          end
        end
        ST_TRAP: begin
          pc          <= TRAP_VECTOR;
          fetch_first <= 1'b1;
          state       <= ST_FETCH;
        end
        ST_HALT: begin
          if (!halt) begin
            fetch_first <= 1'b1;
            state       <= ST_FETCH;
          end
        end
        default: begin
          fetch_first <= 1'b1;
          state       <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: instruction-level PC/retire model with randomized timing.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        halted;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic [31:0] retire_count;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .halt         (halt),
    .halted       (halted),
    .trap         (trap),
    .trap_pc      (trap_pc),
    .trap_tval    (trap_tval),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instruction-level reference state
  logic [31:0] m_pc;
  logic [31:0] m_retire;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.jump_taken  = 1'($urandom);
    bus.jump_target = $urandom;
  endtask

  // Starts on the observation of a FETCH cycle; ends on observation of the following FETCH entry
  // (or of the TRAP cycle's successor). Cycles counted from the first req cycle to the accept edge.
  task automatic run_instr(input int ack_dly, input int rdy_dly, input logic jt,
                           input logic [31:0] tgt, input logic [31:0] data,
                           input logic halt_in_issue, output int cycles);
    logic [31:0] exp_next;
    logic        exp_mis;
    int c = 0;
    total++;
    if (bus.fetch_req !== 1'b1) begin
      bad++; $display("FAIL fetch_req_start act=%b exp=1", bus.fetch_req);
    end
    total++;
    if (bus.fetch_addr !== m_pc) begin
      bad++; $display("FAIL fetch_addr act=%h exp=%h", bus.fetch_addr, m_pc);
    end
    repeat (ack_dly) begin
      noise();
      bus.exec_ready = 1'($urandom);
      bus.fetch_ack  = 1'b0;
      step(); c++;
      total++;
      if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== m_pc || bus.instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL fetch_wait req=%b addr=%h vld=%b exp req=1 addr=%h vld=0",
                 bus.fetch_req, bus.fetch_addr, bus.instr_valid, m_pc);
      end
    end
    bus.fetch_ack  = 1'b1;
    bus.fetch_data = data;
    bus.exec_ready = 1'b0;
    step(); c++;
    bus.fetch_ack  = 1'b0;
    bus.fetch_data = $urandom;
    if (halt_in_issue) halt = 1'b1;
    total++;
    if (bus.instr_valid !== 1'b1 || bus.fetch_req !== 1'b0) begin
      bad++; $display("FAIL issue_entry vld=%b req=%b exp vld=1 req=0", bus.instr_valid, bus.fetch_req);
    end
    total++;
    if (bus.instr !== data || bus.instr_pc !== m_pc) begin
      bad++; $display("FAIL issue_latch instr=%h pc=%h exp instr=%h pc=%h", bus.instr, bus.instr_pc, data, m_pc);
    end
    repeat (rdy_dly) begin
      noise();
      bus.exec_ready = 1'b0;
      step(); c++;
      total++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== data || bus.instr_pc !== m_pc || bus.fetch_req !== 1'b0) begin
        bad++;
        $display("FAIL issue_hold vld=%b instr=%h pc=%h req=%b exp vld=1 instr=%h pc=%h req=0",
                 bus.instr_valid, bus.instr, bus.instr_pc, bus.fetch_req, data, m_pc);
      end
    end
    bus.exec_ready  = 1'b1;
    bus.jump_taken  = jt;
    bus.jump_target = tgt;
    step(); c++;
    bus.exec_ready = 1'b0;
    noise();
    exp_next = jt ? tgt : m_pc + 32'd4;
    exp_mis  = jt && (tgt[1:0] != 2'b00);
    total++;
    if (bus.instr_valid !== 1'b0) begin
      bad++; $display("FAIL valid_drop act=%b exp=0", bus.instr_valid);
    end
    if (exp_mis) begin
      total++;
      if (trap !== 1'b1 || trap_pc !== m_pc || trap_tval !== tgt || retire_count !== m_retire) begin
        bad++;
        $display("FAIL trap_cycle trap=%b pc=%h tval=%h ret=%0d exp trap=1 pc=%h tval=%h ret=%0d",
                 trap, trap_pc, trap_tval, retire_count, m_pc, tgt, m_retire);
      end
      m_pc = 32'h0000_0100;
      step();
      total++;
      if (trap !== 1'b0 || bus.fetch_addr !== m_pc || bus.fetch_req !== 1'b1) begin
        bad++;
        $display("FAIL trap_exit trap=%b addr=%h req=%b exp trap=0 addr=%h req=1",
                 trap, bus.fetch_addr, bus.fetch_req, m_pc);
      end
    end else begin
      m_pc     = exp_next;
      m_retire = m_retire + 32'd1;
      total++;
      if (trap !== 1'b0 || retire_count !== m_retire || bus.fetch_addr !== m_pc) begin
        bad++;
        $display("FAIL accept trap=%b ret=%0d addr=%h exp trap=0 ret=%0d addr=%h",
                 trap, retire_count, bus.fetch_addr, m_retire, m_pc);
      end
      total++;
      if (bus.fetch_req !== ~halt) begin
        bad++; $display("FAIL next_req act=%b exp=%b", bus.fetch_req, ~halt);
      end
    end
    cycles = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0;
    bus.fetch_ack = 1'b0; bus.fetch_data = '0; bus.exec_ready = 1'b0;
    bus.jump_taken = 1'b0; bus.jump_target = '0;
    step(); step();
    total++;
    if (bus.fetch_req !== 1'b0 || bus.fetch_addr !== 32'h0 || bus.instr_valid !== 1'b0) begin
      bad++; $display("FAIL reset_ctl req=%b addr=%h vld=%b exp 0/0/0", bus.fetch_req, bus.fetch_addr, bus.instr_valid);
    end
    total++;
    if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0 || halted !== 1'b0 || trap !== 1'b0) begin
      bad++; $display("FAIL reset_out instr=%h ipc=%h halted=%b trap=%b exp all 0", bus.instr, bus.instr_pc, halted, trap);
    end
    total++;
    if (trap_pc !== 32'h0 || trap_tval !== 32'h0 || retire_count !== 32'h0) begin
      bad++; $display("FAIL reset_regs tpc=%h tval=%h ret=%0d exp all 0", trap_pc, trap_tval, retire_count);
    end
    rst = 1'b0;
    step();
    m_pc = 32'h0; m_retire = 32'h0;
  endtask

  task automatic test_sequential();
    int cyc;
    for (int i = 0; i < 2; i++) begin
      run_instr(1, 0, 1'b0, 32'h0, $urandom, 1'b0, cyc);
      total++;
      if (cyc != 3) begin
        bad++; $display("FAIL seq_latency act=%0d exp=3", cyc);
      end
    end
  endtask

  task automatic test_taken_jump();
    int cyc;
    run_instr(1, 2, 1'b1, 32'h0000_0040, $urandom, 1'b0, cyc);
    total++;
    if (retire_count !== 32'd3) begin
      bad++; $display("FAIL jump_retire act=%0d exp=3", retire_count);
    end
    run_instr(1, 0, 1'b1, 32'h0000_0010, $urandom, 1'b0, cyc);
  endtask

  task automatic test_misaligned();
    int cyc;
    run_instr(1, 1, 1'b1, 32'h0000_0042, $urandom, 1'b0, cyc);
    total++;
    if (trap_pc !== 32'h10 || trap_tval !== 32'h42 || retire_count !== 32'd4) begin
      bad++; $display("FAIL misaligned_regs tpc=%h tval=%h ret=%0d exp 10/42/4", trap_pc, trap_tval, retire_count);
    end
  endtask

  task automatic test_stalls();
    int cyc;
    run_instr(5, 4, 1'b0, 32'h0, $urandom, 1'b0, cyc);
    total++;
    if (cyc != 11) begin
      bad++; $display("FAIL stall_latency act=%0d exp=11", cyc);
    end
  endtask

  task automatic test_halt();
    int cyc;
    run_instr(2, 1, 1'b0, 32'h0, $urandom, 1'b1, cyc);
    repeat (4) begin
      step();
      total++;
      if (halted !== 1'b1 || bus.fetch_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
        bad++; $display("FAIL halt_idle halted=%b req=%b vld=%b exp 1/0/0", halted, bus.fetch_req, bus.instr_valid);
      end
    end
    halt = 1'b0;
    step();
    total++;
    if (halted !== 1'b0 || bus.fetch_req !== 1'b1 || bus.fetch_addr !== m_pc) begin
      bad++; $display("FAIL halt_resume halted=%b req=%b addr=%h exp 0/1/%h", halted, bus.fetch_req, bus.fetch_addr, m_pc);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    run_instr(1, 0, 1'b1, 32'hFFFF_FFFC, $urandom, 1'b0, cyc);
    run_instr(1, 0, 1'b0, 32'h0, $urandom, 1'b0, cyc);
    total++;
    if (bus.fetch_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_addr act=%h exp=00000000", bus.fetch_addr);
    end
  endtask

  task automatic test_random();
    int cyc;
    logic [31:0] tgt;
    logic jt;
    for (int i = 0; i < 40; i++) begin
      jt  = 1'($urandom);
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      run_instr($urandom_range(1, 3), $urandom_range(0, 3), jt, tgt, $urandom, 1'b0, cyc);
    end
  endtask

  task automatic test_reset_mid_fetch();
    step();
    rst = 1'b1;
    bus.fetch_ack  = 1'b1;
    bus.fetch_data = 32'hDEAD_BEEF;
    step();
    bus.fetch_ack = 1'b0;
    total++;
    if (bus.instr_valid !== 1'b0 || bus.fetch_addr !== 32'h0 || bus.fetch_req !== 1'b0) begin
      bad++; $display("FAIL rst_ack vld=%b addr=%h req=%b exp 0/0/0", bus.instr_valid, bus.fetch_addr, bus.fetch_req);
    end
    total++;
    if (retire_count !== 32'h0 || bus.instr !== 32'h0) begin
      bad++; $display("FAIL rst_ack_regs ret=%0d instr=%h exp 0/0", retire_count, bus.instr);
    end
    rst = 1'b0;
    step();
    total++;
    if (bus.instr_valid !== 1'b0 || bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h0) begin
      bad++; $display("FAIL rst_resume vld=%b req=%b addr=%h exp 0/1/0", bus.instr_valid, bus.fetch_req, bus.fetch_addr);
    end
    m_pc = 32'h0; m_retire = 32'h0;
  endtask

  task automatic test_after_reset();
    int cyc;
    run_instr(1, 0, 1'b0, 32'h0, $urandom, 1'b0, cyc);
    total++;
    if (retire_count !== 32'd1) begin
      bad++; $display("FAIL post_reset_retire act=%0d exp=1", retire_count);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_taken_jump();
    test_misaligned();
    test_stalls();
    test_halt();
    test_wrap();
    test_random();
    test_reset_mid_fetch();
    test_after_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural program counter for the single-issue RISC-V core.
- Fetches each instruction through a request/acknowledge memory port and presents it to the decode/execute stage.
- At the execute handshake, samples the resolution from the combinational control-transfer unit (Should_Jump / PC_Out) to choose the next PC.
- Raises a trap on a misaligned jump target, supports halt, and counts retired instructions.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded after a misaligned-target trap.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_req  output  1  instruction read request.
- fetch_addr  output  32  read address, always equals pc.
- fetch_ack  input  1  memory returns fetch_data this cycle.
- fetch_data  input  32  instruction word.
- instr_valid  output  1  instr/instr_pc valid for execute.
- instr  output  32  held instruction word.
- instr_pc  output  32  PC of held instruction.
- exec_ready  input  1  execute accepts instr this cycle; also drives the control unit's Enabled.
- jump_taken  input  1  Should_Jump from the control-transfer unit, meaningful only in the accept cycle.
- jump_target  input  32  PC_Out from the control-transfer unit.
- halt  input  1  stop fetching at the next instruction boundary.
- halted  output  1  sequencer idle in HALT.
- trap  output  1  one-cycle pulse on misaligned target.
- trap_pc  output  32  instr_pc of the trapping instruction, held until the next trap.
- trap_tval  output  32  offending target, held until the next trap.
- retire_count  output  32  instructions accepted without trap.

Behaviour:
- Reset (rst=1 at an edge):
  - state=FETCH, pc=RESET_VECTOR.
  - All outputs 0 except fetch_addr=RESET_VECTOR; retire_count=0.
  - Reset overrides everything, including in-flight fetches; any fetch_ack in the reset cycle is discarded.
- States: FETCH, ISSUE, TRAP, HALT.
- FETCH:
  - If halt=1 on state entry, go to HALT without asserting fetch_req.
  - Otherwise assert fetch_req with fetch_addr=pc, held stable until fetch_ack.
  - On fetch_ack: latch instr=fetch_data and instr_pc=pc; go to ISSUE.
  - fetch_req drops in the cycle after ack.
  - Minimum latency is one cycle from req to ack.
- ISSUE:
  - instr_valid=1; instr and instr_pc are held until exec_ready=1.
  - Accept cycle = instr_valid & exec_ready. In that cycle:
    - Compute next = jump_taken ? jump_target : instr_pc + 4, with 32-bit wrap (FFFF_FFFC+4 = 0).
    - If jump_taken and jump_target[1:0] != 0: go to TRAP, latch trap_pc and trap_tval, retire_count unchanged.
    - Otherwise: pc=next, retire_count+=1 (wraps at 2^32), go to FETCH.
  - instr_valid drops the cycle after accept.
  - jump_taken/jump_target are ignored in every other cycle.
- TRAP:
  - trap=1 for exactly this cycle; pc=TRAP_VECTOR; go to FETCH.
- HALT:
  - halted=1, no fetch.
  - When halt=0, go to FETCH at the current pc.
  - halt asserted during FETCH or ISSUE never aborts the current instruction; it is honoured at the next FETCH entry.
- Throughput:
  - Best case is one instruction per 3 cycles (FETCH req, ack to ISSUE, accept).
  - Back-to-back acceptance is not supported; no prefetch.
- Both outputs fetch_req and instr_valid are never high simultaneously.

Decomposition:
- Shared package pc_seq_pkg:
  - state enum {FETCH, ISSUE, TRAP, HALT}.
  - INSTR_BYTES=4.
  - Default vector constants.
- Sub-module next_pc_select (combinational):
  - Inputs: instr_pc, jump_taken, jump_target.
  - Outputs: next pc, misaligned flag.
  - Reused by a future prefetch variant.
- The FSM, retire counter and trap registers live in pc_sequencer.

Test Plan:
- Reset then sequential run: rst 1 cycle, ack each fetch after 1 cycle, jump_taken=0 -> fetch_addr sequence 0x0,0x4,0x8; retire_count=3 after 3 accepts; each instruction takes 3 cycles.
- Taken jump: at instr_pc=0x8, jump_taken=1, jump_target=0x40 -> next fetch_addr=0x40, retire_count increments; jump_taken pulses outside accept cycles have no effect.
- Misaligned target: instr_pc=0x10, jump_target=0x42 -> trap high exactly 1 cycle, trap_pc=0x10, trap_tval=0x42, next fetch_addr=0x100, retire_count unchanged.
- Stalls: fetch_ack delayed 5 cycles and exec_ready held low 4 cycles -> fetch_addr, instr and instr_pc stable throughout; single accept per instruction.
- Halt: halt raised during ISSUE -> current instruction accepted, halted=1 with no fetch_req; halt released -> fetch resumes at next pc.
- Reset mid-fetch with simultaneous fetch_ack, plus wrap: rst during ack -> no instr_valid, fetch_addr=RESET_VECTOR; separately pc=0xFFFF_FFFC sequential -> next fetch_addr=0x0.
